// File: rtl/reg_wb_unit.sv
// Register-file write-port arbiter: ALU results take priority, MDU results wait in a
// small FIFO; writes to $0 are dropped and pending writes are reported to decode.
module reg_wb_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_wrA,
  input  logic [DATA_W-1:0] alu_wrD,
  input  logic              mdu_valid,
  input  logic [ADDR_W-1:0] mdu_wrA,
  input  logic [DATA_W-1:0] mdu_wrD,
  output logic              mdu_ready,
  input  logic [ADDR_W-1:0] q1A,
  input  logic [ADDR_W-1:0] q2A,
  output logic              q1_pend,
  output logic              q2_pend,
  output logic              regW,
  output logic [ADDR_W-1:0] wrA,
  output logic [DATA_W-1:0] wrD
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [ADDR_W-1:0] fifo_a [DEPTH];
  logic [DATA_W-1:0] fifo_d [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       count;
  logic              alu_sel;
  logic              push;
  logic              pop;

  assign mdu_ready = !rst && (count < FULL);
  assign alu_sel   = alu_valid && (alu_wrA != '0);
  // Accepted $0 results complete the handshake but never occupy a slot.
  assign push      = mdu_valid && mdu_ready && (mdu_wrA != '0);
  assign pop       = !alu_sel && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= mdu_wrA;
      fifo_d[wr_ptr] <= mdu_wrD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regW   <= 1'b0;
      wrA    <= '0;
      wrD    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (alu_sel) begin
        regW <= 1'b1;
        wrA  <= alu_wrA;
        wrD  <= alu_wrD;
      end else if (pop) begin
        regW <= 1'b1;
        wrA  <= fifo_a[rd_ptr];
        wrD  <= fifo_d[rd_ptr];
      end else begin
        regW <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  logic [PW-1:0] offs;
  always_comb begin
    q1_pend = 1'b0;
    q2_pend = 1'b0;
    offs    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr;
      if ({1'b0, offs} < count) begin
        if (fifo_a[i] == q1A) q1_pend = 1'b1;
        if (fifo_a[i] == q2A) q2_pend = 1'b1;
      end
    end
    if (regW && (wrA == q1A)) q1_pend = 1'b1;
    if (regW && (wrA == q2A)) q2_pend = 1'b1;
    if (q1A == '0) q1_pend = 1'b0;
    if (q2A == '0) q2_pend = 1'b0;
  end
endmodule

// File: tb/tb_reg_wb_unit.sv
// Directed bench for reg_wb_unit: expected register-file writes are queued by the
// stimulus in hand-computed order and matched by a monitor watching regW.
module tb_reg_wb_unit;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_wrA;
  logic [DATA_W-1:0] alu_wrD;
  logic              mdu_valid;
  logic [ADDR_W-1:0] mdu_wrA;
  logic [DATA_W-1:0] mdu_wrD;
  logic              mdu_ready;
  logic [ADDR_W-1:0] q1A;
  logic [ADDR_W-1:0] q2A;
  logic              q1_pend;
  logic              q2_pend;
  logic              regW;
  logic [ADDR_W-1:0] wrA;
  logic [DATA_W-1:0] wrD;

  int total = 0;
  int bad   = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  reg_wb_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_wrA(alu_wrA), .alu_wrD(alu_wrD),
    .mdu_valid(mdu_valid), .mdu_wrA(mdu_wrA), .mdu_wrD(mdu_wrD),
    .mdu_ready(mdu_ready),
    .q1A(q1A), .q2A(q2A), .q1_pend(q1_pend), .q2_pend(q2_pend),
    .regW(regW), .wrA(wrA), .wrD(wrD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic alu(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    alu_valid = v; alu_wrA = a; alu_wrD = d;
  endtask

  task automatic mdu(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    mdu_valid = v; mdu_wrA = a; mdu_wrD = d;
  endtask

  // Monitor: every committed write must be the next expected one.
  always @(negedge clk) begin
    if (regW === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected actual=%0h/%0h required=none", wrA, wrD);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({wrA, wrD} !== e) begin
          bad++;
          $display("FAIL wr_order actual=%0h/%0h required=%0h/%0h",
                   wrA, wrD, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    alu(1'b0, '0, '0);
    mdu(1'b0, '0, '0);
    q1A = 5'd3;
    q2A = 5'd5;

    // Reset held two cycles
    tick();
    tick();
    chk("rst_regW", 64'(regW), 64'd0);
    chk("rst_wrA", 64'(wrA), 64'd0);
    chk("rst_wrD", 64'(wrD), 64'd0);
    chk("rst_ready", 64'(mdu_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(mdu_ready), 64'd1);
    chk("q1_pend_idle", 64'(q1_pend), 64'd0);
    chk("q2_pend_idle", 64'(q2_pend), 64'd0);

    // ALU write r3=100
    alu(1'b1, 5'd3, 32'd100);
    expect_wr(5'd3, 32'd100);
    tick();
    alu(1'b0, '0, '0);
    #1;
    chk("alu_lat_regW", 64'(regW), 64'd1);
    chk("alu_lat_wrA", 64'(wrA), 64'd3);
    chk("alu_lat_wrD", 64'(wrD), 64'd100);
    chk("pend_uncommitted", 64'(q1_pend), 64'd1);
    tick();
    chk("pend_committed", 64'(q1_pend), 64'd0);

    // ALU write to $0 is suppressed; wrA/wrD hold
    alu(1'b1, 5'd0, 32'd55);
    tick();
    alu(1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("r0_regW", 64'(regW), 64'd0);
      tick();
    end
    chk("hold_wrA", 64'(wrA), 64'd3);
    chk("hold_wrD", 64'(wrD), 64'd100);

    // ALU r1..r3 back to back, MDU r5=7 accepted alongside r1
    q1A = 5'd5;
    q2A = 5'd0;
    alu(1'b1, 5'd1, 32'd11);
    mdu(1'b1, 5'd5, 32'd7);
    #1;
    chk("t4_ready", 64'(mdu_ready), 64'd1);
    expect_wr(5'd1, 32'd11);
    expect_wr(5'd2, 32'd22);
    expect_wr(5'd3, 32'd33);
    expect_wr(5'd5, 32'd7);
    tick();
    alu(1'b1, 5'd2, 32'd22);
    mdu(1'b0, '0, '0);
    #1;
    chk("t4_pend_n1", 64'(q1_pend), 64'd1);
    chk("q2_zero_never_pend", 64'(q2_pend), 64'd0);
    tick();
    alu(1'b1, 5'd3, 32'd33);
    #1;
    chk("t4_pend_n2", 64'(q1_pend), 64'd1);
    tick();
    alu(1'b0, '0, '0);
    #1;
    chk("t4_pend_n3", 64'(q1_pend), 64'd1);
    tick();
    chk("t4_regW_n4", 64'(regW), 64'd1);
    chk("t4_wrA_n4", 64'(wrA), 64'd5);
    chk("t4_wrD_n4", 64'(wrD), 64'd7);
    chk("t4_pend_n4", 64'(q1_pend), 64'd1);
    tick();
    chk("t4_pend_n5", 64'(q1_pend), 64'd0);
    chk("t4_regW_n5", 64'(regW), 64'd0);

    // ALU busy fills the FIFO; third MDU offer is held back
    expect_wr(5'd10, 32'd1000);
    expect_wr(5'd11, 32'd1001);
    expect_wr(5'd12, 32'd1002);
    expect_wr(5'd6, 32'd1);
    expect_wr(5'd7, 32'd2);
    expect_wr(5'd8, 32'd3);
    q2A = 5'd8;
    alu(1'b1, 5'd10, 32'd1000);
    mdu(1'b1, 5'd6, 32'd1);
    tick();
    alu(1'b1, 5'd11, 32'd1001);
    mdu(1'b1, 5'd7, 32'd2);
    #1;
    chk("t5_ready_1", 64'(mdu_ready), 64'd1);
    tick();
    alu(1'b1, 5'd12, 32'd1002);
    mdu(1'b1, 5'd8, 32'd3);
    #1;
    chk("t5_ready_full", 64'(mdu_ready), 64'd0);
    chk("t5_r8_not_pend", 64'(q2_pend), 64'd0);
    tick();
    alu(1'b0, '0, '0);
    #1;
    chk("t5_ready_full2", 64'(mdu_ready), 64'd0);
    tick();
    chk("t5_ready_again", 64'(mdu_ready), 64'd1);
    chk("t5_wrA_r6", 64'(wrA), 64'd6);
    tick();
    mdu(1'b0, '0, '0);
    #1;
    chk("t5_r8_pend", 64'(q2_pend), 64'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("t5_drained", 64'(q2_pend), 64'd0);

    // Accepted MDU write to $0: handshake completes, nothing written
    mdu(1'b1, 5'd0, 32'd9);
    #1;
    chk("r0_mdu_ready", 64'(mdu_ready), 64'd1);
    tick();
    mdu(1'b0, '0, '0);
    #1;
    chk("r0_mdu_regW1", 64'(regW), 64'd0);
    tick();
    chk("r0_mdu_regW2", 64'(regW), 64'd0);
    chk("r0_mdu_ready_after", 64'(mdu_ready), 64'd1);

    // Fill FIFO with r6/r7, then reset discards them
    q1A = 5'd6;
    q2A = 5'd7;
    expect_wr(5'd20, 32'd1);
    expect_wr(5'd21, 32'd2);
    alu(1'b1, 5'd20, 32'd1);
    mdu(1'b1, 5'd6, 32'h66);
    tick();
    alu(1'b1, 5'd21, 32'd2);
    mdu(1'b1, 5'd7, 32'h77);
    tick();
    alu(1'b0, '0, '0);
    mdu(1'b0, '0, '0);
    #1;
    chk("t6_full", 64'(mdu_ready), 64'd0);
    chk("t6_pend6", 64'(q1_pend), 64'd1);
    chk("t6_pend7", 64'(q2_pend), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_ready_in_rst", 64'(mdu_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_regW", 64'(regW), 64'd0);
    chk("t6_ready", 64'(mdu_ready), 64'd1);
    chk("t6_pend6_clr", 64'(q1_pend), 64'd0);
    chk("t6_pend7_clr", 64'(q2_pend), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
